// File: rtl/axi_bram_responder.sv
// ----------------------------------------------------------------------------
// axi_bram_responder
//
// AXI4 responder backed by on-chip block RAM. It uses the same AXI port set as
// the DDR3 core's main AXI port, so it can stand in as the memory target when
// no DDR3 PHY or model is present. It serves one transaction at a time and
// supports FIXED and INCR bursts. Reserved bursts (and WRAP unless enabled)
// run to completion with SLVERR, do not write the RAM, and return zero data.
//
// Optional feature macro: AXI_BRAM_WRAP_BURST_EN
//   When defined, WRAP bursts with len 1/3/7/15 wrap inside an aligned window
//   of len+1 words. Any other WRAP length is answered with SLVERR.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   axi_aw*               write address channel (valid/ready/addr/id/len/burst)
//   axi_w*                write data channel (valid/ready/last/strb/data)
//   axi_b*                write response channel (valid/ready/resp/id)
//   axi_ar*               read address channel (valid/ready/addr/id/len/burst)
//   axi_r*                read data channel (valid/ready/last/resp/id/data)
// ----------------------------------------------------------------------------
module axi_bram_responder #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRS         = 27,
  parameter int unsigned MEM_WORD_BITS = 10,
  parameter int unsigned AXI_ID_WIDTH  = 4
) (
  input  logic                      clock,
  input  logic                      reset,

  input  logic                      axi_awvalid_i,
  output logic                      axi_awready_o,
  input  logic [ADDRS-1:0]          axi_awaddr_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_awid_i,
  input  logic [7:0]                axi_awlen_i,
  input  logic [1:0]                axi_awburst_i,

  input  logic                      axi_wvalid_i,
  output logic                      axi_wready_o,
  input  logic                      axi_wlast_i,
  input  logic [DATA_WIDTH/8-1:0]   axi_wstrb_i,
  input  logic [DATA_WIDTH-1:0]     axi_wdata_i,

  output logic                      axi_bvalid_o,
  input  logic                      axi_bready_i,
  output logic [1:0]                axi_bresp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_bid_o,

  input  logic                      axi_arvalid_i,
  output logic                      axi_arready_o,
  input  logic [ADDRS-1:0]          axi_araddr_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_arid_i,
  input  logic [7:0]                axi_arlen_i,
  input  logic [1:0]                axi_arburst_i,

  output logic                      axi_rvalid_o,
  input  logic                      axi_rready_i,
  output logic                      axi_rlast_o,
  output logic [1:0]                axi_rresp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_rid_o,
  output logic [DATA_WIDTH-1:0]     axi_rdata_o
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(NUM_LANES);
  localparam int unsigned DEPTH     = 1 << MEM_WORD_BITS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RDATA
  } state_e;

  state_e                    state_q;
  logic                      rd_prio_q;
  logic [MEM_WORD_BITS-1:0]  idx_q;
  logic [MEM_WORD_BITS-1:0]  idx_d;
  logic [7:0]                cnt_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [1:0]                burst_q;
  logic                      err_q;
  logic                      wl_err_q;
`ifdef AXI_BRAM_WRAP_BURST_EN
  logic [MEM_WORD_BITS-1:0]  wrap_mask_q;
`endif

  // Read pipeline: stage A is the RAM output register, stage B the output
  // register presented on the R channel.
  logic                      iss_done_q;
  logic                      a_valid_q;
  logic                      a_last_q;
  logic [DATA_WIDTH-1:0]     ram_q;

  logic                      bvalid_q;
  logic [1:0]                bresp_q;
  logic [AXI_ID_WIDTH-1:0]   bid_q;
  logic                      rvalid_q;
  logic                      rlast_q;
  logic [1:0]                rresp_q;
  logic [AXI_ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0]     rdata_q;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic                      aw_hs;
  logic                      ar_hs;
  logic                      w_hs;
  logic                      ram_we;
  logic                      b_load;
  logic                      rd_en;
  logic [MEM_WORD_BITS-1:0]  req_idx;
  logic [7:0]                req_len;
  logic [1:0]                req_burst;
  logic                      req_bad;

  // Sub-word and aliasing address bits are deliberately ignored.
  logic                      unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr_i, axi_araddr_i};

  // ---------------------------------------------------------------------------
  // Handshakes. Only one of the two address readies can be high while both
  // valids are asserted, so at most one request is granted per cycle.
  // ---------------------------------------------------------------------------
  assign axi_awready_o = ~reset & (state_q == S_IDLE) & ~(axi_arvalid_i & rd_prio_q);
  assign axi_arready_o = ~reset & (state_q == S_IDLE) & ~(axi_awvalid_i & ~rd_prio_q);
  assign axi_wready_o  = ~reset & (state_q == S_WDATA);

  assign aw_hs  = axi_awready_o & axi_awvalid_i;
  assign ar_hs  = axi_arready_o & axi_arvalid_i;
  assign w_hs   = axi_wready_o & axi_wvalid_i;
  assign ram_we = w_hs & ~err_q;

  // Stage B accepts when empty or draining; a new RAM read is issued only
  // when stage A is empty or moving into B, so nothing is ever overwritten.
  assign b_load = ~reset & (state_q == S_RDATA) & a_valid_q & (~rvalid_q | axi_rready_i);
  assign rd_en  = ~reset & (state_q == S_RDATA) & ~iss_done_q & (~a_valid_q | b_load);

  assign axi_bvalid_o = bvalid_q;
  assign axi_bresp_o  = bresp_q;
  assign axi_bid_o    = bid_q;
  assign axi_rvalid_o = rvalid_q;
  assign axi_rlast_o  = rlast_q;
  assign axi_rresp_o  = rresp_q;
  assign axi_rid_o    = rid_q;
  assign axi_rdata_o  = rdata_q;

  // ---------------------------------------------------------------------------
  // Request decode for whichever address channel is being granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_idx   = ar_hs ? axi_araddr_i[LANE_BITS +: MEM_WORD_BITS]
                      : axi_awaddr_i[LANE_BITS +: MEM_WORD_BITS];
    req_len   = ar_hs ? axi_arlen_i   : axi_awlen_i;
    req_burst = ar_hs ? axi_arburst_i : axi_awburst_i;
    req_bad   = 1'b1;
    case (req_burst)
      2'b00, 2'b01: req_bad = 1'b0;
`ifdef AXI_BRAM_WRAP_BURST_EN
      2'b10:        req_bad = !(req_len inside {8'd1, 8'd3, 8'd7, 8'd15});
`endif
      default:      req_bad = 1'b1;
    endcase
  end

  // Next word index for the active burst.
  always_comb begin
    idx_d = idx_q;
    case (burst_q)
      2'b01: idx_d = idx_q + MEM_WORD_BITS'(1);
`ifdef AXI_BRAM_WRAP_BURST_EN
      2'b10: idx_d = (idx_q & ~wrap_mask_q) | ((idx_q + MEM_WORD_BITS'(1)) & wrap_mask_q);
`endif
      default: idx_d = idx_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Block RAM: byte-lane writes, registered read with enable. Not reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < NUM_LANES; b++) begin
        if (axi_wstrb_i[b]) begin
          mem[idx_q][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      ram_q <= mem[idx_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered channel outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_prio_q   <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      wl_err_q    <= 1'b0;
`ifdef AXI_BRAM_WRAP_BURST_EN
      wrap_mask_q <= '0;
`endif
      iss_done_q  <= 1'b0;
      a_valid_q   <= 1'b0;
      a_last_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      bid_q       <= '0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rresp_q     <= '0;
      rid_q       <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (aw_hs || ar_hs) begin
            idx_q      <= req_idx;
            cnt_q      <= req_len;
            burst_q    <= req_burst;
            err_q      <= req_bad;
            id_q       <= ar_hs ? axi_arid_i : axi_awid_i;
            wl_err_q   <= 1'b0;
            iss_done_q <= 1'b0;
            a_valid_q  <= 1'b0;
`ifdef AXI_BRAM_WRAP_BURST_EN
            wrap_mask_q <= MEM_WORD_BITS'(req_len);
`endif
            if (axi_awvalid_i && axi_arvalid_i) begin
              rd_prio_q <= ~rd_prio_q;
            end
            state_q <= ar_hs ? S_RDATA : S_WDATA;
          end
        end

        // The burst length comes from the beat counter; wlast is only checked.
        S_WDATA: begin
          if (w_hs) begin
            if (cnt_q == '0) begin
              state_q  <= S_WRESP;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (err_q || wl_err_q || !axi_wlast_i) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              cnt_q <= cnt_q - 8'd1;
              idx_q <= idx_d;
              if (axi_wlast_i) begin
                wl_err_q <= 1'b1;
              end
            end
          end
        end

        S_WRESP: begin
          if (axi_bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end

        S_RDATA: begin
          if (rd_en) begin
            a_valid_q <= 1'b1;
            a_last_q  <= (cnt_q == '0);
            if (cnt_q == '0) begin
              iss_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
              idx_q <= idx_d;
            end
          end else if (b_load) begin
            a_valid_q <= 1'b0;
          end

          if (b_load) begin
            rvalid_q <= 1'b1;
            rlast_q  <= a_last_q;
            rdata_q  <= err_q ? '0 : ram_q;
            rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
            rid_q    <= id_q;
          end else if (axi_rready_i) begin
            rvalid_q <= 1'b0;
          end

          if (rvalid_q && axi_rready_i && rlast_q) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            state_q  <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_bram_responder.md
Name: axi_bram_responder

Overview:
- Synthesisable AXI4 responder backed by on-chip block RAM, with the same AXI port set as the DDR3 core's main AXI port.
- Serves as a drop-in memory target for AXI initiators and bench tasks when no DDR3 PHY or model is present.
- Also a reference responder when checking initiator-side burst, ID and strobe handling.
- Serves one transaction at a time. Supports FIXED and INCR bursts.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; byte lanes = DATA_WIDTH/8.
- ADDRS, 27, AXI byte-address width.
- MEM_WORD_BITS, 10, log2 of RAM depth in DATA_WIDTH words.
- AXI_ID_WIDTH, 4, transaction ID width.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- axi_awvalid_i  in  1; axi_awready_o  out  1; axi_awaddr_i  in  ADDRS; axi_awid_i  in  AXI_ID_WIDTH; axi_awlen_i  in  8; axi_awburst_i  in  2
- axi_wvalid_i  in  1; axi_wready_o  out  1; axi_wlast_i  in  1; axi_wstrb_i  in  DATA_WIDTH/8; axi_wdata_i  in  DATA_WIDTH
- axi_bvalid_o  out  1; axi_bready_i  in  1; axi_bresp_o  out  2; axi_bid_o  out  AXI_ID_WIDTH
- axi_arvalid_i  in  1; axi_arready_o  out  1; axi_araddr_i  in  ADDRS; axi_arid_i  in  AXI_ID_WIDTH; axi_arlen_i  in  8; axi_arburst_i  in  2
- axi_rvalid_o  out  1; axi_rready_i  in  1; axi_rlast_o  out  1; axi_rresp_o  out  2; axi_rid_o  out  AXI_ID_WIDTH; axi_rdata_o  out  DATA_WIDTH

Behaviour:
- Single clock `clock`. `reset` is synchronous and active-high.
- While reset is high, every output is 0: all ready, valid, last, resp, id and rdata outputs. RAM contents are not cleared.
- A reset asserted mid-transaction abandons that transaction. The FSM returns to IDLE and outputs are 0 after the next edge.
- FSM states:
  - IDLE: accepts a request.
  - WDATA: AW accepted; collecting W beats.
  - WRESP: B held until accepted.
  - RDATA: issuing R beats.
- IDLE readies:
  - axi_awready_o = IDLE & ~(axi_arvalid_i & rd_prio).
  - axi_arready_o = IDLE & ~(axi_awvalid_i & ~rd_prio).
  - Readies may depend combinationally on valids. At most one handshake occurs per cycle.
  - rd_prio resets to 0 (write wins) and toggles whenever both valids were high at a grant.
- Word index = addr[MEM_WORD_BITS+1:2] for DATA_WIDTH=32, generally addr bits above the byte-lane bits. Sub-word address bits are ignored. Upper bits alias, so the index wraps modulo depth.
- Burst handling:
  - INCR (01): index +1 per beat, wrapping modulo depth.
  - FIXED (00): index unchanged across beats.
  - Reserved (11), and WRAP (10) when the optional feature is absent: burst still fully executed with resp SLVERR (2'b10). The RAM is not written; rdata reads 0.
- Beat count = len+1, held in an 8-bit down-counter.
- WDATA:
  - axi_wready_o is high throughout.
  - Each W handshake writes the lanes whose wstrb bit is set.
  - The burst ends on the counter, not on wlast.
  - If wlast is high on a non-final beat, or low on the final beat, bresp = SLVERR. Otherwise OKAY (00).
- WRESP:
  - axi_bvalid_o rises on the edge after the final W handshake, with axi_bid_o equal to the captured awid.
  - Held until bready; returns to IDLE on the B handshake edge.
  - A new AW can be granted the cycle after the B handshake.
- RDATA:
  - Synchronous RAM read. If the AR handshake is at edge N, axi_rvalid_o is first high after edge N+2.
  - With rready held high: one beat per cycle, no bubbles.
  - With rready low: rdata, rlast and rid are held stable (prefetch/skid register).
  - axi_rid_o = captured arid. axi_rlast_o is high only on beat len+1.
  - Returns to IDLE on the rlast handshake.
- Read-after-write to the same word in consecutive transactions returns the new data.

Optional Feature:
- Macro: AXI_BRAM_WRAP_BURST_EN.
- Defined:
  - burst 10 wraps within an aligned window of (len+1) words; the window base = index with its low log2(len+1) bits cleared.
  - len must be 1, 3, 7 or 15. Any other len gives SLVERR with the error behaviour above.
- Undefined: WRAP is treated as reserved, i.e. SLVERR, no RAM write, rdata 0.

Test Plan:
- Write then read:
  - Write: AW addr 0x0, len 3, id 2, INCR, 4 random words, wstrb 0xf, B with rready/bready high -> bvalid 1 cycle after the 4th W beat, bid 2, bresp 00.
  - Read: AR addr 0x0, len 3, id 4 -> first rvalid 2 cycles after AR, same 4 words, rid 4, rlast on beat 4 only.
- Strobes: write 0xAABBCCDD to addr 0x10, then wstrb 0x5 with 0x11223344 -> read of addr 0x10 returns 0xAA22CC44.
- Contention:
  - AW and AR asserted in the same cycle after reset -> AW granted first.
  - Repeat both once more -> AR granted first (rd_prio toggled).
- Backpressure: read len 7, rready toggled 1-0-0-1 pattern -> 8 beats, rdata stable while stalled, no dropped or duplicated beats.
- Errors:
  - wlast high on beat 2 of a len-3 burst -> all 4 beats consumed, bresp 10.
  - AR with burst 11 -> 1+len beats, rresp 10, rdata 0.
- Reset: reset asserted during the 3rd R beat -> next cycle all outputs 0; a fresh write/read then completes normally.
